// File: rtl/mmio_serial_fifo_pkg.sv
// Shared definitions for the buffered MMIO serial port: register map,
// STATUS/CTRL bit positions and the TX drain state encoding.
package mmio_serial_fifo_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_THRESH = 2'd3;

  localparam int ST_TX_NOT_FULL  = 0;
  localparam int ST_RX_NOT_EMPTY = 1;
  localparam int ST_RX_OVF       = 2;
  localparam int ST_TX_OVF       = 3;
  localparam int ST_RX_CNT_LSB   = 8;
  localparam int ST_TX_CNT_LSB   = 16;

  localparam int CTRL_RX_EN = 0;
  localparam int CTRL_TX_EN = 1;
  localparam int CTRL_LOOP  = 2;
  localparam logic [2:0] CTRL_RST = 3'b011;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_e;

endpackage

// File: rtl/mmio_serial_fifo_if.sv
// MMIO access bus between the processor decode and the serial port block.
// Reads return data with valid one cycle after the strobe.
interface mmio_serial_fifo_if #(
  parameter int ADDR_W = 4
);
  logic              oe;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [31:0]       rdata;
  logic              valid;

  modport master (output oe, we, addr, wdata, input rdata, valid);
  modport slave  (input oe, we, addr, wdata, output rdata, valid);
endinterface

// File: rtl/mmio_serial_fifo_fifo.sv
// Synchronous FIFO with combinational head; pushes onto a full FIFO are dropped
// (even with a same-cycle pop) and pops from an empty FIFO are ignored.
module mmio_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  CLK,
  input  logic                  RST_X,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int PW    = DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/mmio_serial_fifo.sv
// Buffered MMIO serial port: RX/TX FIFOs, sticky overruns, loopback and an RX
// threshold interrupt in front of the existing UART serialiser pair.
module mmio_serial_fifo
  import mmio_serial_fifo_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int ADDR_W     = 4
) (
  input  logic                 CLK,
  input  logic                 RST_X,
  mmio_serial_fifo_if.slave    bus,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_we,
  input  logic                 tx_ready,
  output logic                 irq
);
  localparam int CW = DEPTH_LOG2 + 1;

  logic [ADDR_W-1:0] addr_w;
  logic [1:0]        sel;
  logic              rd_acc, wr_acc, w1c;
  logic [2:0]        ctrl;
  logic [DEPTH_LOG2:0] thresh;
  logic              rx_ovf, tx_ovf;
  tx_state_e         state;
  logic              send_lb;

  logic              rx_push, rx_pop, rx_full, rx_empty, ext_push, lb_push;
  logic [7:0]        rx_din, rx_head;
  logic [CW-1:0]     rx_count, rx_cnt_nxt;
  logic              tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]        tx_head;
  logic [CW-1:0]     tx_count;
  logic [31:0]       status_w, rd_mux;
  logic              unused_bits;

  assign addr_w = bus.addr;
  assign sel    = addr_w[3:2];
  assign rd_acc = bus.oe && !bus.we;
  assign wr_acc = bus.oe && bus.we;
  assign w1c    = wr_acc && (sel == REG_STATUS);
  assign unused_bits = ^{bus.wdata[31:8], addr_w};

  // The loopback byte is the one latched on tx_data while in SEND.
  assign lb_push  = (state == TX_SEND) && send_lb;
  assign ext_push = rx_valid && ctrl[CTRL_RX_EN] && !ctrl[CTRL_LOOP];
  assign rx_push  = lb_push || ext_push;
  assign rx_din   = lb_push ? tx_data : rx_data;
  assign rx_pop   = rd_acc && (sel == REG_DATA);

  assign tx_push = wr_acc && (sel == REG_DATA);
  assign tx_pop  = (state == TX_IDLE) && ctrl[CTRL_TX_EN] && !tx_empty
                   && (tx_ready || ctrl[CTRL_LOOP]);

  mmio_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
    .CLK(CLK), .RST_X(RST_X), .push(rx_push), .pop(rx_pop), .din(rx_din),
    .dout(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );

  mmio_sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
    .CLK(CLK), .RST_X(RST_X), .push(tx_push), .pop(tx_pop), .din(bus.wdata[7:0]),
    .dout(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );

  assign rx_cnt_nxt = rx_count + CW'(rx_push && !rx_full) - CW'(rx_pop && !rx_empty);

  always_comb begin
    status_w = '0;
    status_w[ST_TX_NOT_FULL]             = !tx_full;
    status_w[ST_RX_NOT_EMPTY]            = !rx_empty;
    status_w[ST_RX_OVF]                  = rx_ovf;
    status_w[ST_TX_OVF]                  = tx_ovf;
    status_w[ST_RX_CNT_LSB +: 8]         = 8'(rx_count);
    status_w[ST_TX_CNT_LSB +: 8]         = 8'(tx_count);
  end

  always_comb begin
    rd_mux = '0;
    case (sel)
      REG_DATA:   rd_mux = rx_empty ? 32'h8000_0000 : {24'b0, rx_head};
      REG_STATUS: rd_mux = status_w;
      REG_CTRL:   rd_mux = {29'b0, ctrl};
      REG_THRESH: rd_mux = 32'(thresh);
      default:    rd_mux = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      ctrl      <= CTRL_RST;
      thresh    <= '0;
      rx_ovf    <= 1'b0;
      tx_ovf    <= 1'b0;
      bus.rdata <= '0;
      bus.valid <= 1'b0;
      irq       <= 1'b0;
    end else begin
      bus.valid <= rd_acc;
      if (rd_acc) bus.rdata <= rd_mux;
      if (wr_acc && (sel == REG_CTRL))   ctrl   <= bus.wdata[2:0];
      if (wr_acc && (sel == REG_THRESH)) thresh <= bus.wdata[DEPTH_LOG2:0];
      // A new overrun in the same cycle as its W1C keeps the flag set.
      rx_ovf <= (rx_ovf && !(w1c && bus.wdata[ST_RX_OVF])) || (rx_push && rx_full);
      tx_ovf <= (tx_ovf && !(w1c && bus.wdata[ST_TX_OVF])) || (tx_push && tx_full);
      irq    <= (thresh != '0) && (rx_cnt_nxt >= thresh);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      state   <= TX_IDLE;
      tx_data <= '0;
      tx_we   <= 1'b0;
      send_lb <= 1'b0;
    end else begin
      case (state)
        TX_IDLE: if (tx_pop) begin
          tx_data <= tx_head;
          tx_we   <= !ctrl[CTRL_LOOP];
          send_lb <= ctrl[CTRL_LOOP];
          state   <= TX_SEND;
        end
        TX_SEND: begin
          tx_we   <= 1'b0;
          send_lb <= 1'b0;
          state   <= TX_GAP;
        end
        // GAP ignores tx_ready while the UART's ready output catches up.
        TX_GAP:  state <= TX_IDLE;
        default: state <= TX_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mmio_serial_fifo.sv
// Directed bench for mmio_serial_fifo (DEPTH_LOG2=2): register table plus
// hand-written TX drain, loopback, interrupt and reset sequences.
module tb_mmio_serial_fifo;
  logic       CLK = 1'b0;
  logic       RST_X = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_we;
  logic       tx_ready = 1'b1;
  logic       irq;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  logic [7:0] pq_d[$];
  int         pq_c[$];

  always #5 CLK = ~CLK;

  mmio_serial_fifo_if #(.ADDR_W(4)) bus ();

  mmio_serial_fifo #(.DEPTH_LOG2(2), .ADDR_W(4)) dut (
    .CLK(CLK), .RST_X(RST_X), .bus(bus), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_we(tx_we), .tx_ready(tx_ready), .irq(irq)
  );

  always @(negedge CLK) begin
    cyc++;
    if (tx_we) begin
      pq_d.push_back(tx_data);
      pq_c.push_back(cyc);
    end
  end

  localparam int K_RD = 0, K_WR = 1, K_RX = 2;
  typedef struct {
    int          kind;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input int k, input logic [3:0] a, input logic [31:0] d, input logic [31:0] e);
    vec_t v;
    v.kind = k; v.addr = a; v.data = d; v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mm_wr(input logic [3:0] a, input logic [31:0] d);
    bus.oe = 1'b1; bus.we = 1'b1; bus.addr = a; bus.wdata = d;
    tick(1);
    bus.oe = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd_chk(input string name, input logic [3:0] a, input logic [31:0] exp);
    bus.oe = 1'b1; bus.we = 1'b0; bus.addr = a;
    tick(1);
    bus.oe = 1'b0;
    check({name, "_valid"}, 32'(bus.valid), 32'd1);
    check(name, bus.rdata, exp);
  endtask

  task automatic rx_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    tick(1);
    rx_valid = 1'b0;
  endtask

  initial begin
    bus.oe = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
    tick(3);
    RST_X = 1'b1;
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_tx_we", 32'(tx_we), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);

    add(K_RD, 4'h4, 0, 32'h0000_0001);
    add(K_RD, 4'h8, 0, 32'h0000_0003);
    add(K_RD, 4'hC, 0, 32'h0000_0000);
    add(K_RX, 0, 32'h41, 0); add(K_RX, 0, 32'h42, 0); add(K_RX, 0, 32'h43, 0);
    add(K_RD, 4'h4, 0, 32'h0000_0303);
    add(K_RD, 4'h0, 0, 32'h41); add(K_RD, 4'h0, 0, 32'h42); add(K_RD, 4'h0, 0, 32'h43);
    add(K_RD, 4'h0, 0, 32'h8000_0000);
    add(K_RD, 4'h0, 0, 32'h8000_0000);
    for (int b = 0; b < 5; b++) add(K_RX, 0, 32'(b), 0);
    add(K_RD, 4'h4, 0, 32'h0000_0407);
    for (int b = 0; b < 4; b++) add(K_RD, 4'h0, 0, 32'(b));
    add(K_RD, 4'h4, 0, 32'h0000_0005);
    add(K_WR, 4'h4, 32'h4, 0);
    add(K_RD, 4'h4, 0, 32'h0000_0001);
    add(K_WR, 4'h8, 32'hFFFF_FFF7, 0);
    add(K_RD, 4'h8, 0, 32'h0000_0007);
    add(K_WR, 4'h8, 32'h3, 0);
    add(K_WR, 4'hC, 32'hFFFF_FFFF, 0);
    add(K_RD, 4'hC, 0, 32'h0000_0007);
    add(K_WR, 4'hC, 32'h0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].kind)
        K_RD:    rd_chk($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp);
        K_WR:    mm_wr(tbl[i].addr, tbl[i].data);
        default: rx_byte(tbl[i].data[7:0]);
      endcase
    end

    // TX drain with a ready transmitter
    pq_d.delete(); pq_c.delete();
    mm_wr(4'h0, 32'h55);
    mm_wr(4'h0, 32'hAA);
    tick(12);
    check("tx_pulses", 32'(pq_d.size()), 32'd2);
    if (pq_d.size() == 2) begin
      check("tx_byte0", 32'(pq_d[0]), 32'h55);
      check("tx_byte1", 32'(pq_d[1]), 32'hAA);
      check("tx_spacing_ge3", 32'(pq_c[1] - pq_c[0] >= 3), 32'd1);
    end

    // Stalled transmitter, then TX overrun, then drain
    pq_d.delete(); pq_c.delete();
    tx_ready = 1'b0;
    mm_wr(4'h0, 32'h11);
    mm_wr(4'h0, 32'h22);
    tick(8);
    check("tx_stall_pulses", 32'(pq_d.size()), 32'd0);
    rd_chk("tx_stall_status", 4'h4, 32'h0002_0001);
    mm_wr(4'h0, 32'h33); mm_wr(4'h0, 32'h44); mm_wr(4'h0, 32'h66);
    rd_chk("tx_ovf_status", 4'h4, 32'h0004_0008);
    mm_wr(4'h4, 32'h8);
    tx_ready = 1'b1;
    tick(20);
    check("tx_drain_pulses", 32'(pq_d.size()), 32'd4);
    if (pq_d.size() == 4) begin
      check("tx_drain_b0", 32'(pq_d[0]), 32'h11);
      check("tx_drain_b3", 32'(pq_d[3]), 32'h44);
    end
    rd_chk("tx_drained_status", 4'h4, 32'h0000_0001);

    // Loopback: TX byte returns through RX; external rx_valid ignored
    pq_d.delete(); pq_c.delete();
    tx_ready = 1'b0;
    mm_wr(4'h8, 32'h7);
    mm_wr(4'h0, 32'h5A);
    tick(6);
    rx_byte(8'h99);
    check("lb_no_tx_we", 32'(pq_d.size()), 32'd0);
    rd_chk("lb_data", 4'h0, 32'h0000_005A);
    rd_chk("lb_empty", 4'h0, 32'h8000_0000);
    mm_wr(4'h8, 32'h3);
    tx_ready = 1'b1;

    // RX threshold interrupt
    mm_wr(4'hC, 32'h2);
    rx_byte(8'h10);
    check("irq_one_byte", 32'(irq), 32'd0);
    rx_byte(8'h20);
    check("irq_two_bytes", 32'(irq), 32'd1);
    rd_chk("irq_pop", 4'h0, 32'h10);
    check("irq_after_pop", 32'(irq), 32'd0);
    tick(1);
    check("valid_drops", 32'(bus.valid), 32'd0);
    check("rdata_holds", bus.rdata, 32'h10);

    // Reset with bytes buffered in both directions
    tx_ready = 1'b0;
    rx_byte(8'h01);
    mm_wr(4'h0, 32'h77);
    RST_X = 1'b0;
    tick(1);
    RST_X = 1'b1;
    check("mid_rst_irq", 32'(irq), 32'd0);
    check("mid_rst_tx_we", 32'(tx_we), 32'd0);
    rd_chk("mid_rst_status", 4'h4, 32'h0000_0001);
    rd_chk("mid_rst_thresh", 4'hC, 32'h0000_0000);
    rd_chk("mid_rst_ctrl", 4'h8, 32'h0000_0003);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/mmio_serial_fifo.md
Name: mmio_serial_fifo

Overview:
- Buffered MMIO serial port. Replaces the single-byte unread/hold scheme for the to-host and from-host registers.
- Sits between the processor's MMIO decode (0xF000_xxxx space) and the existing UART serialiser pair (UARTTX, PLOADER receive path).
- Adds parametrised RX/TX FIFOs, sticky overrun flags, loopback, and an RX threshold interrupt.
- Does not serialise bits itself.

Parameters:
- DEPTH_LOG2, 4: log2 of each FIFO depth. Legal range 1..7.
- ADDR_W, 4: width of the register offset input (byte address). Registers at offsets 0x0, 0x4, 0x8, 0xC.

Ports:
- CLK  in  1  clock
- RST_X  in  1  synchronous active-low reset
- oe  in  1  MMIO access strobe (already decoded to this block)
- we  in  1  write enable, qualified by oe
- addr  in  ADDR_W  byte offset; bits [3:2] select the register
- wdata  in  32  write data
- rdata  out  32  read data
- valid  out  1  read data valid
- rx_data  in  8  byte from the receiver
- rx_valid  in  1  one-cycle strobe for rx_data
- tx_data  out  8  byte to the transmitter
- tx_we  out  1  one-cycle transmit strobe
- tx_ready  in  1  transmitter idle
- irq  out  1  RX threshold interrupt, level

Behaviour:
- Reset (RST_X=0 at a CLK edge):
  - FIFOs emptied; overrun flags cleared.
  - CTRL=3'b011 (rx_en=1, tx_en=1, loopback=0); THRESH=0.
  - rdata=0, valid=0, tx_we=0, tx_data=0, irq=0.
  - Reset mid-transfer discards all buffered bytes.
- Read timing: a read (oe && !we) returns rdata with valid=1 exactly one cycle later. valid=0 otherwise. rdata holds its last value when valid=0.
- Write timing: a write takes effect at the accept edge.
- Register 0x0 DATA:
  - Read pops the RX FIFO and returns {~rx_nonempty, 23'b0, head}.
  - Read when empty returns 32'h8000_0000 and changes no state.
  - Write pushes wdata[7:0] into the TX FIFO.
  - Write when TX is full drops the byte and sets tx_ovf.
- Register 0x4 STATUS, read-only except W1C bits:
  - bit0 tx_not_full; bit1 rx_not_empty; bit2 rx_ovf; bit3 tx_ovf.
  - [15:8] rx_count, zero-extended; [23:16] tx_count, zero-extended.
  - Writing 1 to bit2 or bit3 clears that flag. If a W1C and a new overrun occur in the same cycle, the flag stays set.
- Register 0x8 CTRL: bit0 rx_en, bit1 tx_en, bit2 loopback. Other bits read 0.
- Register 0xC THRESH: [DEPTH_LOG2:0] RX threshold.
- Fullness: counts are DEPTH_LOG2+1 bits wide. Full is evaluated on the pre-edge count. Push onto a full FIFO is dropped even if a pop occurs in the same cycle. Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- RX path:
  - rx_valid && rx_en && !loopback pushes rx_data.
  - If full, the byte is dropped and rx_ovf is set.
  - rx_valid is ignored when rx_en=0.
- TX drain FSM, states IDLE, SEND, GAP:
  - IDLE: when tx_en && TX FIFO non-empty && (tx_ready || loopback), pop the head, register it on tx_data, go to SEND.
  - SEND: tx_we=1 for exactly one cycle (forced 0 when loopback). In loopback the byte is pushed into the RX FIFO instead, with RX overrun rules applied. Go to GAP.
  - GAP: one cycle with tx_we=0 and tx_ready not sampled, covering the UARTTX ready lag. Return to IDLE.
  - Net effect: at most one byte per 3 cycles.
  - Clearing tx_en mid-FSM completes the current byte and then halts in IDLE.
- Loopback RX push vs external rx_valid: external rx_valid is ignored while loopback=1, so there is never a double push.
- irq is registered: irq = (THRESH != 0) && (rx_count >= THRESH), using the post-update count. It rises one cycle after the count reaches the threshold.

Decomposition:
- Shared package holds:
  - register offsets: REG_DATA=2'd0, REG_STATUS=2'd1, REG_CTRL=2'd2, REG_THRESH=2'd3;
  - STATUS bit positions;
  - CTRL reset value;
  - TX FSM state encoding.
- One natural sub-module, mmio_sync_fifo:
  - parameters WIDTH and DEPTH_LOG2;
  - push, pop, din, dout (head, combinational), count, full, empty;
  - drop-on-full and ignore-on-empty semantics.
- Instantiated twice: RX and TX, each WIDTH=8.

Test Plan:
- After reset, read STATUS → valid one cycle later, rdata=32'h0000_0001. Read CTRL → 32'h3.
- Three rx_valid pulses 0x41, 0x42, 0x43 → STATUS[15:8]=3. Three DATA reads → 0x41, 0x42, 0x43. Fourth DATA read → 32'h8000_0000.
- DEPTH_LOG2=2: 5 rx_valid bytes 0..4 → rx_count=4, rx_ovf=1, reads return 0..3. Write STATUS 32'h4 → rx_ovf=0.
- tx_ready tied 1: write DATA 0x55 then 0xAA → tx_we pulses with tx_data 0x55 then 0xAA, pulses ≥3 cycles apart. With tx_ready=0, no pulses occur and tx_count holds at 2.
- CTRL=3'b111 (loopback): write DATA 0x5A → tx_we stays 0. DATA read then returns 32'h0000_005A.
- THRESH=2: one rx byte → irq=0. Second byte → irq=1 the next cycle. One DATA read → irq=0.
